// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and tap-offset helper for the CNN
// window feeder. Setting FEEDER_ZERO_PAD_EN selects "same" padding, which
// gives IMG_W window positions per axis instead of IMG_W-K+1.
package cnn_pkg;

    localparam int unsigned IMG_W   = 28;
    localparam int unsigned K       = 5;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WIN_W   = K * K * PIX_W;
    localparam int unsigned NPIX    = IMG_W * IMG_W;
    localparam int unsigned PIX_AW  = $clog2(NPIX);
    localparam int unsigned COORD_W = 5;
    localparam int unsigned TAP_W   = 3;
    localparam int unsigned OFF_W   = $clog2(WIN_W);

`ifdef FEEDER_ZERO_PAD_EN
    localparam int unsigned NPOS = IMG_W;
`else
    localparam int unsigned NPOS = IMG_W - K + 1;
`endif

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        GATHER  = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        ADVANCE = 3'd4
    } feeder_state_e;

    // Bit offset of tap (i, j) inside the packed window.
    function automatic logic [OFF_W-1:0] tap_offset(input logic [TAP_W-1:0] i,
                                                    input logic [TAP_W-1:0] j);
        return OFF_W'((32'(i) * K + 32'(j)) * PIX_W);
    endfunction

endpackage

// File: rtl/cnn_frame_store.sv
// Frame buffer holding one IMG_W x IMG_W frame.
// Ports:
//   CLK        write clock
//   wr_en      write strobe
//   wr_addr    linear write address (raster order)
//   wr_data    pixel written
//   rd_row     read row
//   rd_col     read column
//   rd_data_c  pixel at (rd_row, rd_col), combinational
module cnn_frame_store
    import cnn_pkg::*;
(
    input  logic               CLK,
    input  logic               wr_en,
    input  logic [PIX_AW-1:0]  wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [COORD_W-1:0] rd_row,
    input  logic [COORD_W-1:0] rd_col,
    output logic [PIX_W-1:0]   rd_data_c
);

    logic [PIX_W-1:0]  mem [NPIX];
    logic [PIX_AW-1:0] rd_addr_c;

    // Storage carries no reset; every location is rewritten before it is read.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_addr_c = PIX_AW'(rd_row) * PIX_AW'(IMG_W) + PIX_AW'(rd_col);
    assign rd_data_c = mem[rd_addr_c];

endmodule

// File: rtl/cnn_window_feeder.sv
// Captures a raster frame, then walks it window by window, presenting each
// packed KxK window with its origin to the CNN core and waiting for DONE.
// Optional macro FEEDER_ZERO_PAD_EN: windows centred on each pixel with
// out-of-frame taps reading as zero.
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   PIX_VALID   pixel stream valid
//   PIX_DATA    pixel value, raster order
//   PIX_READY   feeder accepts a pixel this cycle
//   CNN_DONE    DONE level from the core
//   START       one-cycle start pulse to the core
//   X, Y        window column / row origin
//   IMGIN       packed window, tap (i,j) at bits (i*K+j)*PIX_W
//   BUSY        high from first accepted pixel until FRAME_DONE
//   FRAME_DONE  one-cycle pulse after the last window completes
module cnn_window_feeder
    import cnn_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               PIX_VALID,
    input  logic [PIX_W-1:0]   PIX_DATA,
    output logic               PIX_READY,
    input  logic               CNN_DONE,
    output logic               START,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [WIN_W-1:0]   IMGIN,
    output logic               BUSY,
    output logic               FRAME_DONE
);

    feeder_state_e      state_q, state_d;
    logic [PIX_AW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [TAP_W-1:0]   tap_i_q, tap_i_d;
    logic [TAP_W-1:0]   tap_j_q, tap_j_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [WIN_W-1:0]   imgin_q, imgin_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               frame_done_q, frame_done_d;
    logic               pix_ready_q, pix_ready_d;
    logic               done_q;

    logic               wr_en_c;
    logic [COORD_W-1:0] rd_row_c, rd_col_c;
    logic [PIX_W-1:0]   rd_data_c;
    logic [PIX_W-1:0]   tap_pix_c;

    cnn_frame_store u_store (
        .CLK       (CLK),
        .wr_en     (wr_en_c),
        .wr_addr   (pix_cnt_q),
        .wr_data   (PIX_DATA),
        .rd_row    (rd_row_c),
        .rd_col    (rd_col_c),
        .rd_data_c (rd_data_c)
    );

`ifdef FEEDER_ZERO_PAD_EN
    localparam int unsigned SC_W = COORD_W + 1;
    localparam logic signed [SC_W-1:0] PAD_S = SC_W'((K - 1) / 2);
    localparam logic signed [SC_W-1:0] LIM_S = SC_W'(IMG_W);

    logic signed [SC_W-1:0] row_s_c, col_s_c;
    logic                   row_ok_c, col_ok_c;

    // Centred tap address; taps outside the frame are forced to zero.
    always_comb begin
        row_s_c   = signed'(SC_W'(y_q)) + signed'(SC_W'(tap_i_q)) - PAD_S;
        col_s_c   = signed'(SC_W'(x_q)) + signed'(SC_W'(tap_j_q)) - PAD_S;
        row_ok_c  = !row_s_c[SC_W-1] && (row_s_c < LIM_S);
        col_ok_c  = !col_s_c[SC_W-1] && (col_s_c < LIM_S);
        rd_row_c  = row_ok_c ? row_s_c[COORD_W-1:0] : '0;
        rd_col_c  = col_ok_c ? col_s_c[COORD_W-1:0] : '0;
        tap_pix_c = (row_ok_c && col_ok_c) ? rd_data_c : '0;
    end
`else
    // Valid-only windows never leave the frame, so no bounds check is needed.
    always_comb begin
        rd_row_c  = y_q + COORD_W'(tap_i_q);
        rd_col_c  = x_q + COORD_W'(tap_j_q);
        tap_pix_c = rd_data_c;
    end
`endif

    // State and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= LOAD;
            pix_cnt_q    <= '0;
            tap_i_q      <= '0;
            tap_j_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            imgin_q      <= '0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            tap_i_q      <= tap_i_d;
            tap_j_q      <= tap_j_d;
            x_q          <= x_d;
            y_q          <= y_d;
            imgin_q      <= imgin_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            pix_ready_q  <= pix_ready_d;
            done_q       <= CNN_DONE;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        tap_i_d      = tap_i_q;
        tap_j_d      = tap_j_q;
        x_d          = x_q;
        y_d          = y_q;
        imgin_d      = imgin_q;
        busy_d       = busy_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        pix_ready_d  = 1'b0;
        wr_en_c      = 1'b0;

        case (state_q)
            LOAD: begin
                if (PIX_VALID && pix_ready_q) begin
                    wr_en_c   = 1'b1;
                    pix_cnt_d = pix_cnt_q + PIX_AW'(1);
                    busy_d    = 1'b1;
                    if (pix_cnt_q == PIX_AW'(NPIX - 1)) begin
                        state_d = GATHER;
                        x_d     = '0;
                        y_d     = '0;
                        tap_i_d = '0;
                        tap_j_d = '0;
                    end
                end
            end
            GATHER: begin
                imgin_d[tap_offset(tap_i_q, tap_j_q) +: PIX_W] = tap_pix_c;
                if (tap_j_q == TAP_W'(K - 1)) begin
                    tap_j_d = '0;
                    if (tap_i_q == TAP_W'(K - 1)) begin
                        tap_i_d = '0;
                        state_d = ISSUE;
                    end else begin
                        tap_i_d = tap_i_q + TAP_W'(1);
                    end
                end else begin
                    tap_j_d = tap_j_q + TAP_W'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge completes the window.
                if (CNN_DONE && !done_q) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (x_q < COORD_W'(NPOS - 1)) begin
                    x_d     = x_q + COORD_W'(1);
                    state_d = GATHER;
                end else if (y_q < COORD_W'(NPOS - 1)) begin
                    x_d     = '0;
                    y_d     = y_q + COORD_W'(1);
                    state_d = GATHER;
                end else begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    pix_cnt_d    = '0;
                    state_d      = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (state_d == ISSUE) begin
            start_d = 1'b1;
        end
        if (state_d == LOAD) begin
            pix_ready_d = 1'b1;
        end
    end

    assign PIX_READY  = pix_ready_q;
    assign START      = start_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign IMGIN      = imgin_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Self-checking bench for cnn_window_feeder: random and ramp frames checked
// against a frame-array reference model. Honours FEEDER_ZERO_PAD_EN.
module tb_cnn_window_feeder;

    localparam int IW  = 28;
    localparam int KK  = 5;
    localparam int NW  = IW * IW;
`ifdef FEEDER_ZERO_PAD_EN
    localparam int PADT = 2;
    localparam int NP   = IW;
`else
    localparam int PADT = 0;
    localparam int NP   = IW - KK + 1;
`endif
    localparam int NWIN = NP * NP;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         PIX_VALID = 1'b0;
    logic [7:0]   PIX_DATA = '0;
    logic         PIX_READY;
    logic         CNN_DONE = 1'b0;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         BUSY;
    logic         FRAME_DONE;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int fd_cnt = 0;
    bit abort = 1'b0;
    logic [7:0] fr [NW];

    cnn_window_feeder dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .PIX_VALID  (PIX_VALID),
        .PIX_DATA   (PIX_DATA),
        .PIX_READY  (PIX_READY),
        .CNN_DONE   (CNN_DONE),
        .START      (START),
        .X          (X),
        .Y          (Y),
        .IMGIN      (IMGIN),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled with the pre-edge value.
    always @(posedge CLK) begin
        if (START === 1'b1) start_cnt++;
        if (FRAME_DONE === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference window: tap (i,j) reads pixel (y+i-PADT, x+j-PADT), zero outside.
    function automatic logic [199:0] model_win(input int x, input int y);
        logic [199:0] w;
        int r;
        int c;
        w = '0;
        for (int i = 0; i < KK; i++) begin
            for (int j = 0; j < KK; j++) begin
                r = y + i - PADT;
                c = x + j - PADT;
                if (r >= 0 && r < IW && c >= 0 && c < IW) w[(i * KK + j) * 8 +: 8] = fr[r * IW + c];
            end
        end
        return w;
    endfunction

    task automatic load_frame(input bit throttle);
        int k;
        int cyc;
        bit v;
        bit busy_seen;
        k = 0;
        cyc = 0;
        busy_seen = 1'b0;
        if (abort) return;
        while (k < NW && cyc < 5000) begin
            v = throttle ? (cyc % 2 == 0) : 1'b1;
            PIX_VALID = v;
            PIX_DATA = fr[k];
            if (v && PIX_READY === 1'b1) k++;
            tick();
            cyc++;
            if (k == 1 && !busy_seen) begin
                chk("busy_after_first_pixel", 200'(BUSY), 200'(1));
                busy_seen = 1'b1;
            end
        end
        PIX_VALID = 1'b0;
        chk("pixels_accepted", 200'(k), 200'(NW));
        if (k != NW) abort = 1'b1;
        chk("ready_after_last_pixel", 200'(PIX_READY), 200'(0));
        chk("busy_after_load", 200'(BUSY), 200'(1));
        if (throttle) begin
            for (int g = 0; g < 4; g++) begin
                PIX_VALID = (g % 2 == 0);
                PIX_DATA = 8'($urandom);
                tick();
                chk("ready_stays_low", 200'(PIX_READY), 200'(0));
            end
            PIX_VALID = 1'b0;
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (START !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("start_seen", 200'(START), 200'(1));
        if (START !== 1'b1) abort = 1'b1;
    endtask

    task automatic run_windows(input int n_run, input int lat_fixed, input bit hold_first,
                               output logic [199:0] w0, output logic [199:0] wl);
        int x;
        int y;
        int lat;
        logic [199:0] exp_w;
        w0 = '0;
        wl = '0;
        for (int w = 0; w < n_run && !abort; w++) begin
            x = w % NP;
            y = w / NP;
            exp_w = model_win(x, y);
            wait_start();
            if (abort) break;
            chk($sformatf("win%0d_x", w), 200'(X), 200'(x));
            chk($sformatf("win%0d_y", w), 200'(Y), 200'(y));
            chk($sformatf("win%0d_imgin", w), IMGIN, exp_w);
            if (w == 0) w0 = IMGIN;
            if (w == NWIN - 1) wl = IMGIN;
            if (hold_first && w == 0) begin
                // DONE already high at ISSUE: must not complete the window.
                for (int s = 0; s < 8; s++) begin
                    if (s == 6) CNN_DONE = 1'b0;
                    tick();
                    chk($sformatf("hold%0d_x", s), 200'(X), 200'(x));
                    chk($sformatf("hold%0d_y", s), 200'(Y), 200'(y));
                    chk($sformatf("hold%0d_imgin", s), IMGIN, exp_w);
                    chk($sformatf("hold%0d_start", s), 200'(START), 200'(0));
                end
                CNN_DONE = 1'b1;
                tick();
                CNN_DONE = 1'b0;
            end else begin
                lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(5, 1));
                repeat (lat) tick();
                CNN_DONE = 1'b1;
                tick();
                CNN_DONE = 1'b0;
            end
        end
    endtask

    task automatic wait_frame_done(input bit prefeed);
        int n;
        n = 0;
        if (abort) return;
        if (prefeed) begin
            PIX_VALID = 1'b1;
            PIX_DATA = fr[0];
        end
        while (FRAME_DONE !== 1'b1 && n < 100) begin
            if (prefeed) chk("ready_low_before_frame_done", 200'(PIX_READY), 200'(0));
            tick();
            n++;
        end
        chk("frame_done", 200'(FRAME_DONE), 200'(1));
        if (FRAME_DONE !== 1'b1) abort = 1'b1;
        chk("busy_at_frame_done", 200'(BUSY), 200'(0));
        chk("ready_at_frame_done", 200'(PIX_READY), 200'(1));
    endtask

    initial begin
        logic [199:0] w0;
        logic [199:0] wl;
        int s0;
        int f0;
        int t;

        // Reset state
        tick();
        chk("rst_ready", 200'(PIX_READY), 200'(0));
        chk("rst_start", 200'(START), 200'(0));
        chk("rst_x", 200'(X), 200'(0));
        chk("rst_y", 200'(Y), 200'(0));
        chk("rst_imgin", IMGIN, 200'(0));
        chk("rst_busy", 200'(BUSY), 200'(0));
        chk("rst_frame_done", 200'(FRAME_DONE), 200'(0));
        nRST = 1'b1;
        chk("ready_at_release", 200'(PIX_READY), 200'(0));
        tick();
        chk("ready_after_release", 200'(PIX_READY), 200'(1));

        // Frame A: ramp (or all-255 when padded), core latency 3
        for (int k = 0; k < NW; k++) fr[k] = (PADT > 0) ? 8'd255 : 8'(k % 256);
        s0 = start_cnt;
        f0 = fd_cnt;
        load_frame(1'b0);
        run_windows(NWIN, 3, 1'b0, w0, wl);
`ifdef FEEDER_ZERO_PAD_EN
        for (int k = 0; k < KK * KK; k++) begin
            t = ((k / KK) < 2 || (k % KK) < 2) ? 0 : 255;
            chk($sformatf("pad_w0_tap%0d", k), 200'(w0[k * 8 +: 8]), 200'(t));
        end
`else
        chk("ramp_w0_b0", 200'(w0[0 +: 8]), 200'(0));
        chk("ramp_w0_b4", 200'(w0[32 +: 8]), 200'(4));
        chk("ramp_w0_b5", 200'(w0[40 +: 8]), 200'(28));
        chk("ramp_w0_b24", 200'(w0[192 +: 8]), 200'(116));
        chk("ramp_wlast_b0", 200'(wl[0 +: 8]), 200'(155));
`endif

        // Frame B: back-to-back, throttled, DONE held high at first ISSUE
        for (int k = 0; k < NW; k++) fr[k] = 8'($urandom);
        wait_frame_done(1'b1);
        load_frame(1'b1);
        chk("frame_a_starts", 200'(start_cnt - s0), 200'(NWIN));
        chk("frame_a_done_pulses", 200'(fd_cnt - f0), 200'(1));
        s0 = start_cnt;
        f0 = fd_cnt;
        CNN_DONE = 1'b1;
        run_windows(NWIN, 0, 1'b1, w0, wl);
        wait_frame_done(1'b0);
        tick();
        tick();
        chk("frame_b_starts", 200'(start_cnt - s0), 200'(NWIN));
        chk("frame_b_done_pulses", 200'(fd_cnt - f0), 200'(1));

        // Frame C: reset during GATHER of window (5,3)
        for (int k = 0; k < NW; k++) fr[k] = 8'($urandom);
        s0 = start_cnt;
        f0 = fd_cnt;
        load_frame(1'b0);
        run_windows(3 * NP + 5, 0, 1'b0, w0, wl);
        tick();
        tick();
        chk("pre_reset_x", 200'(X), 200'(5));
        chk("pre_reset_y", 200'(Y), 200'(3));
        nRST = 1'b0;
        #1;
        chk("mid_rst_ready", 200'(PIX_READY), 200'(0));
        chk("mid_rst_start", 200'(START), 200'(0));
        chk("mid_rst_x", 200'(X), 200'(0));
        chk("mid_rst_y", 200'(Y), 200'(0));
        chk("mid_rst_imgin", IMGIN, 200'(0));
        chk("mid_rst_busy", 200'(BUSY), 200'(0));
        chk("mid_rst_frame_done", 200'(FRAME_DONE), 200'(0));
        tick();
        nRST = 1'b1;
        chk("ready_at_release2", 200'(PIX_READY), 200'(0));
        tick();
        chk("ready_after_release2", 200'(PIX_READY), 200'(1));
        chk("frame_c_starts", 200'(start_cnt - s0), 200'(3 * NP + 5));
        chk("frame_c_no_done", 200'(fd_cnt - f0), 200'(0));

        // Frame D: full random frame after reset, random core latency
        for (int k = 0; k < NW; k++) fr[k] = 8'($urandom);
        s0 = start_cnt;
        f0 = fd_cnt;
        load_frame(1'b0);
        run_windows(NWIN, 0, 1'b0, w0, wl);
        wait_frame_done(1'b0);
        tick();
        tick();
        chk("frame_d_starts", 200'(start_cnt - s0), 200'(NWIN));
        chk("frame_d_done_pulses", 200'(fd_cnt - f0), 200'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
